// File: rtl/shift_pipe_16_pkg.sv
// Shared widths, direction encoding and the per-stage pipeline record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pipe_16_pkg;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef struct packed {
        logic               valid;
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        dir_e               dir;
        logic               arith;
        logic               lost;
    } stage_t;

endpackage

// File: rtl/shift_pipe_16_if.sv
// Command and result handshake bundle for the pipelined shifter.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready stall on each side.
interface shift_pipe_16_if;
    import shift_pipe_16_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_dir;
    logic               in_arith;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_lost;

    modport master (
        output in_valid, in_data, in_shamt, in_dir, in_arith, out_ready,
        input  in_ready, out_valid, out_data, out_lost
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, in_arith, out_ready,
        output in_ready, out_valid, out_data, out_lost
    );

endinterface

// File: rtl/shift_pipe_16_stage.sv
// One registered shift step of STEP bits, taken when shamt[SEL] is set.
// Latency: 1 cycle.
// Backpressure: advances when empty or when the next stage advances; holds otherwise.
module shift_pipe_stage
    import shift_pipe_16_pkg::*;
#(
    parameter int STEP = 8,
    parameter int SEL  = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  stage_t prev,
    input  logic   adv_next,
    output stage_t cur,
    output logic   adv
);

    logic [WIDTH-1:0] shifted;
    logic             lost_now;
    stage_t           nxt;

    // Arithmetic fill can use the current bit 15: earlier stages replicate the original sign.
    always_comb begin
        shifted  = prev.data;
        lost_now = 1'b0;
        if (prev.shamt[SEL]) begin
            if (prev.dir == DIR_LEFT) begin
                shifted  = prev.data << STEP;
                lost_now = |prev.data[WIDTH-1 -: STEP];
            end else if (prev.arith) begin
                shifted  = $signed(prev.data) >>> STEP;
            end else begin
                shifted  = prev.data >> STEP;
                lost_now = |prev.data[STEP-1:0];
            end
        end
    end

    always_comb begin
        nxt      = prev;
        nxt.data = shifted;
        nxt.lost = prev.lost | lost_now;
    end

    assign adv = !cur.valid || adv_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
        end else if (adv) begin
            cur <= nxt;
        end
    end

endmodule

// File: rtl/shift_pipe_16.sv
// Four-stage pipelined 16-bit barrel shifter (shift by 8, 4, 2, 1) with lost-bit flag.
// Latency: 4 cycles from accept to out_valid; one result per cycle when unstalled.
// Backpressure: out_ready stalls ripple back stage by stage; empty stages keep filling.
module shift_pipe_16
    import shift_pipe_16_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    shift_pipe_16_if.slave  bus
);

    stage_t s0, s1, s2, s3, s4;
    logic   adv1, adv2, adv3, adv4;

    always_comb begin
        s0       = '0;
        s0.valid = bus.in_valid;
        s0.data  = bus.in_data;
        s0.shamt = bus.in_shamt;
        s0.dir   = dir_e'(bus.in_dir);
        s0.arith = bus.in_arith;
        s0.lost  = 1'b0;
    end

    shift_pipe_stage #(.STEP(8), .SEL(3)) u_st8 (
        .clk(clk), .rst(rst), .prev(s0), .adv_next(adv2), .cur(s1), .adv(adv1)
    );

    shift_pipe_stage #(.STEP(4), .SEL(2)) u_st4 (
        .clk(clk), .rst(rst), .prev(s1), .adv_next(adv3), .cur(s2), .adv(adv2)
    );

    shift_pipe_stage #(.STEP(2), .SEL(1)) u_st2 (
        .clk(clk), .rst(rst), .prev(s2), .adv_next(adv4), .cur(s3), .adv(adv3)
    );

    shift_pipe_stage #(.STEP(1), .SEL(0)) u_st1 (
        .clk(clk), .rst(rst), .prev(s3), .adv_next(bus.out_ready), .cur(s4), .adv(adv4)
    );

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s4.valid;
    assign bus.out_data  = s4.data;
    assign bus.out_lost  = s4.lost;

    // Control fields are spent by the last stage.
    logic unused_fields;
    assign unused_fields = ^{s4.shamt, s4.dir, s4.arith};

endmodule

// File: tb/tb_shift_pipe_16.sv
// Directed bench for shift_pipe_16: latency, shift/fill/lost cases, stall, bubbles, reset.
module tb_shift_pipe_16;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];

    shift_pipe_16_if bus_if ();

    shift_pipe_16 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!rst && bus_if.out_valid && bus_if.out_ready)
            got_q.push_back({bus_if.out_lost, bus_if.out_data});
    end

    function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] s,
                                          input logic dr, input logic a);
        logic [31:0]        x;
        logic signed [31:0] y;
        logic [16:0]        r;
        if (!dr) begin
            x = {16'h0, d} << s;
            r = {|x[31:16], x[15:0]};
        end else if (a) begin
            y = {d, 16'h0};
            y = y >>> s;
            r = {1'b0, y[31:16]};
        end else begin
            x = {d, 16'h0} >> s;
            r = {|x[15:0], x[31:16]};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] s, input logic dr,
                        input logic a, input logic rand_ord);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        bus_if.in_shamt = s;
        bus_if.in_dir   = dr;
        bus_if.in_arith = a;
        while (!acc && n < 64) begin
            if (rand_ord) bus_if.out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = bus_if.in_ready;
            tick();
            n++;
        end
        bus_if.in_valid = 1'b0;
        chk("send_accept", 32'(acc), 32'd1);
        if (acc) exp_q.push_back(model(d, s, dr, a));
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!bus_if.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, 32'(bus_if.out_valid), 32'd1);
    endtask

    task automatic run_one(input string tag, input logic [15:0] d, input logic [3:0] s,
                           input logic dr, input logic a,
                           input logic [15:0] ed, input logic el);
        bus_if.out_ready = 1'b1;
        send(d, s, dr, a, 1'b0);
        wait_out(tag);
        chk({tag, "_dat"},  32'(bus_if.out_data), 32'(ed));
        chk({tag, "_lost"}, 32'(bus_if.out_lost), 32'(el));
        tick();
    endtask

    task automatic compare_q(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_item%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    logic [15:0] bp_d [6] = '{16'h1234, 16'h8001, 16'hFFFF, 16'h00F0, 16'hA5A5, 16'h7FFF};
    logic [15:0] bb_d [8] = '{16'hA5A5, 16'h8001, 16'hFFFF, 16'h0100,
                              16'h7FFF, 16'hC003, 16'h0F0F, 16'h8421};

    initial begin
        int   acc;
        int   n;
        logic r;

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.in_shamt  = '0;
        bus_if.in_dir    = 1'b0;
        bus_if.in_arith  = 1'b0;
        bus_if.out_ready = 1'b0;

        tick();
        tick();
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus_if.out_data),  32'd0);
        chk("rst_out_lost",  32'(bus_if.out_lost),  32'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready",  32'(bus_if.in_ready),  32'd1);

        // Latency: presented in cycle T, visible after edge T+4.
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = 16'h00F1;
        bus_if.in_shamt  = 4'd4;
        bus_if.in_dir    = 1'b0;
        bus_if.in_arith  = 1'b0;
        #1;
        chk("lat_in_ready", 32'(bus_if.in_ready), 32'd1);
        tick();
        bus_if.in_valid = 1'b0;
        chk("lat_edge1", 32'(bus_if.out_valid), 32'd0);
        tick();
        chk("lat_edge2", 32'(bus_if.out_valid), 32'd0);
        tick();
        chk("lat_edge3", 32'(bus_if.out_valid), 32'd0);
        tick();
        chk("lat_edge4", 32'(bus_if.out_valid), 32'd1);
        chk("lat_dat",   32'(bus_if.out_data),  32'h0F10);
        chk("lat_lost",  32'(bus_if.out_lost),  32'd0);
        tick();

        run_one("lsl_loss",   16'hF00F, 4'd4,  1'b0, 1'b0, 16'h00F0, 1'b1);
        run_one("lsl_zero",   16'hF00F, 4'd0,  1'b0, 1'b0, 16'hF00F, 1'b0);
        run_one("lsr_15",     16'h8001, 4'd15, 1'b1, 1'b0, 16'h0001, 1'b1);
        run_one("asr_3",      16'h8000, 4'd3,  1'b1, 1'b1, 16'hF000, 1'b0);
        run_one("asr_4",      16'h7FF0, 4'd4,  1'b1, 1'b1, 16'h07FF, 1'b0);
        run_one("asr_noloss", 16'h800F, 4'd4,  1'b1, 1'b1, 16'hF800, 1'b0);
        run_one("lsr_loss",   16'h00FF, 4'd4,  1'b1, 1'b0, 16'h000F, 1'b1);
        run_one("lsr_clean",  16'h00F0, 4'd4,  1'b1, 1'b0, 16'h000F, 1'b0);
        run_one("lsl_arith",  16'h0001, 4'd15, 1'b0, 1'b1, 16'h8000, 1'b0);
        run_one("lsl_15",     16'hFFFF, 4'd15, 1'b0, 1'b0, 16'h8000, 1'b1);

        // Back-pressure: fill the pipe with out_ready low, then drain.
        got_q.delete();
        exp_q.delete();
        bus_if.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = bp_d[acc];
            bus_if.in_shamt = 4'(acc + 1);
            bus_if.in_dir   = acc[0];
            bus_if.in_arith = 1'b0;
            #1;
            r = bus_if.in_ready;
            tick();
            if (r) begin
                exp_q.push_back(model(bp_d[acc], 4'(acc + 1), acc[0], 1'b0));
                acc++;
            end
        end
        chk("bp_accepts", 32'(acc), 32'd4);
        #1;
        chk("bp_in_ready",  32'(bus_if.in_ready),  32'd0);
        chk("bp_out_valid", 32'(bus_if.out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_dat",  32'(bus_if.out_data), 32'(exp_q[0][15:0]));
            chk("bp_hold_lost", 32'(bus_if.out_lost), 32'(exp_q[0][16]));
        end
        bus_if.out_ready = 1'b1;
        n = 0;
        while (acc < 6 && n < 20) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = bp_d[acc];
            bus_if.in_shamt = 4'(acc + 1);
            bus_if.in_dir   = acc[0];
            bus_if.in_arith = 1'b0;
            #1;
            r = bus_if.in_ready;
            tick();
            if (r) begin
                exp_q.push_back(model(bp_d[acc], 4'(acc + 1), acc[0], 1'b0));
                acc++;
            end
            n++;
        end
        bus_if.in_valid = 1'b0;
        n = 0;
        while (got_q.size() < 6 && n < 30) begin
            tick();
            n++;
        end
        compare_q("bp");

        // Bubbles: one command every other cycle under random out_ready.
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            send(bb_d[i], 4'((i * 5 + 1) % 16), i[0], i[1], 1'b1);
            bus_if.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus_if.out_ready = 1'b1;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 40) begin
            tick();
            n++;
        end
        compare_q("bubble");

        // Reset with three commands in flight.
        tick();
        got_q.delete();
        exp_q.delete();
        bus_if.out_ready = 1'b1;
        send(16'h1111, 4'd1, 1'b0, 1'b0, 1'b0);
        send(16'h2222, 4'd2, 1'b1, 1'b0, 1'b0);
        send(16'h8888, 4'd3, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(bus_if.in_ready),  32'd1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.out_valid) n++;
        end
        chk("mid_rst_no_stale", 32'(n), 32'd0);
        chk("mid_rst_no_xfer",  32'(got_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
